mult_pipe_param: RTL



---
 rtl/mult_pipe_param.sv | 110 +++++++++++
 1 files changed

// File: rtl/mult_pipe_param.sv
// Pipelined A x B multiplier: B split into 17-bit limbs summed by a systolic adder cascade, latency NB+2 enabled cycles.
// Optional running accumulator on the product stream when MULT_ACC_EN is defined.
module mult_pipe_param #(
  parameter int A_WIDTH   = 25,
  parameter int B_WIDTH   = 35,
  parameter int SIGNED    = 0,
  parameter int ACC_GUARD = 8
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               CE,
  input  logic                               IN_VALID,
  input  logic [A_WIDTH-1:0]                 A_IN,
  input  logic [B_WIDTH-1:0]                 B_IN,
`ifdef MULT_ACC_EN
  input  logic                               ACC_CLR,
  output logic [A_WIDTH+B_WIDTH+ACC_GUARD-1:0] ACC_OUT,
`endif
  output logic [A_WIDTH+B_WIDTH-1:0]         PROD_OUT,
  output logic                               OUT_VALID
);

  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int NB = ((B_WIDTH + 15) / 17 < 1) ? 1 : (B_WIDTH + 15) / 17;

  if (A_WIDTH < 2 || A_WIDTH > 25 || B_WIDTH < 2 || B_WIDTH > 69 || ACC_GUARD < 1)
  begin : g_bad_params
    $error("mult_pipe_param: parameter out of range");
  end

  // index 0 is the input register; index k+1 belongs to cascade stage k
  logic [A_WIDTH-1:0] a_q   [0:NB-1];
  logic [B_WIDTH-1:0] b_q   [0:NB-1];
  logic [PW-1:0]      p_q   [1:NB];
  logic [PW-1:0]      p_nxt [0:NB-1];
  logic [NB:0]        v_q;
`ifdef MULT_ACC_EN
  logic [NB:0]        clr_q;
`endif

  for (genvar k = 0; k < NB; k++) begin : g_stage
    localparam int LO = 17 * k;
    localparam int LW = (k == NB - 1) ? B_WIDTH - LO : 17;
    localparam bit SX = (SIGNED != 0) && (k == NB - 1);
    logic [PW-1:0] a_x;
    logic [PW-1:0] limb_x;
    logic [PW-1:0] pp;
    logic [PW-1:0] p_in;

    // operands extended to full product width so the mod-2^PW sum is exact in both modes
    assign a_x    = {{B_WIDTH{(SIGNED != 0) & a_q[k][A_WIDTH-1]}}, a_q[k]};
    assign limb_x = {{(PW-LW){SX & b_q[k][LO+LW-1]}}, b_q[k][LO +: LW]};
    assign pp     = a_x * limb_x;

    if (k == 0) begin : g_first
      assign p_in = '0;
    end else begin : g_next
      assign p_in = p_q[k];
    end

    assign p_nxt[k] = p_in + (pp << LO);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < NB; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
      end
      for (int s = 1; s <= NB; s++) p_q[s] <= '0;
      v_q <= '0;
`ifdef MULT_ACC_EN
      clr_q <= '0;
`endif
    end else if (CE) begin
      a_q[0] <= A_IN;
      b_q[0] <= B_IN;
      v_q    <= {v_q[NB-1:0], IN_VALID};
`ifdef MULT_ACC_EN
      clr_q  <= {clr_q[NB-1:0], ACC_CLR};
`endif
      for (int s = 1; s < NB; s++) begin
        a_q[s] <= a_q[s-1];
        b_q[s] <= b_q[s-1];
      end
      for (int s = 1; s <= NB; s++) p_q[s] <= p_nxt[s-1];
    end
  end

  // OUT_VALID is rewritten every cycle so a stalled token never pulses twice
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PROD_OUT  <= '0;
      OUT_VALID <= 1'b0;
`ifdef MULT_ACC_EN
      ACC_OUT   <= '0;
`endif
    end else begin
      OUT_VALID <= CE & v_q[NB];
      if (CE && v_q[NB]) begin
        PROD_OUT <= p_q[NB];
`ifdef MULT_ACC_EN
        ACC_OUT  <= (clr_q[NB] ? '0 : ACC_OUT)
                    + {{ACC_GUARD{(SIGNED != 0) & p_q[NB][PW-1]}}, p_q[NB]};
`endif
      end
    end
  end

endmodule
